// File: rtl/itim_pkg.sv
// Shared sizing helpers and the fetch/write address check for the ITIM.
package itim_pkg;

  // Defaults for the common 32-bit, 4 KiB configuration.
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_BITS  = 10;
  localparam int unsigned BYTES          = DEF_DATA_WIDTH / 8;
  localparam int unsigned OFFS_BITS      = $clog2(BYTES);
  localparam int unsigned MEM_BYTES      = BYTES << DEF_ADDR_BITS;

  function automatic int unsigned bytes_of(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned offs_bits_of(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

  function automatic logic [32:0] mem_bytes_of(input int unsigned dw, input int unsigned ab);
    return 33'(dw / 8) << ab;
  endfunction

  // True when a byte address is below the base, past the end, or not word aligned.
  // Done in 33 bits so the upper bound never wraps.
  function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned dw, input int unsigned ab);
    logic [32:0] off;
    logic [31:0] mask;
    off  = {1'b0, addr} - {1'b0, base};
    mask = 32'(dw / 8) - 32'd1;
    return (addr < base) || (off >= mem_bytes_of(dw, ab)) || ((addr & mask) != 32'd0);
  endfunction

endpackage

// File: rtl/itim_ram.sv
module itim_ram
  import itim_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter string       IMEM_HEX   = ""
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [ADDR_BITS-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  (* ram_style = "block", rom_style = "block" *)
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < DATA_WIDTH/8; b++)
          if (wstrb_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/itim_sync.sv
// Instruction TIM: fetch handshake with held response, flush, error path and loader write port.
module itim_sync
  import itim_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter string       IMEM_HEX   = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    itim_i_valid,
  output logic                    itim_o_ready,
  input  logic [31:0]             itim_i_addr,
  input  logic                    itim_i_flush,
  output logic                    itim_o_rvalid,
  input  logic                    itim_i_rready,
  output logic [DATA_WIDTH-1:0]   itim_o_rdata,
  output logic                    itim_o_rerr,
  input  logic                    itim_i_wvalid,
  output logic                    itim_o_wready,
  input  logic [31:0]             itim_i_waddr,
  input  logic [DATA_WIDTH-1:0]   itim_i_wdata,
  input  logic [DATA_WIDTH/8-1:0] itim_i_wstrb
);

  localparam int unsigned OFFS = offs_bits_of(DATA_WIDTH);

  logic                  rvalid_q, rvalid_d;
  logic                  rerr_q, rerr_d;
  logic                  fetch_bad, write_bad, accept;
  logic                  ram_en, ram_we;
  logic [ADDR_BITS-1:0]  fetch_idx, write_idx, ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign fetch_bad = addr_bad(itim_i_addr, BASE_ADDR, DATA_WIDTH, ADDR_BITS);
  assign write_bad = addr_bad(itim_i_waddr, BASE_ADDR, DATA_WIDTH, ADDR_BITS);
  assign fetch_idx = ADDR_BITS'((itim_i_addr - BASE_ADDR) >> OFFS);
  assign write_idx = ADDR_BITS'((itim_i_waddr - BASE_ADDR) >> OFFS);

  // Writes own the port; a fetch may only be taken when the slot frees up.
  assign itim_o_wready = 1'b1;
  assign itim_o_ready  = !itim_i_wvalid && (!rvalid_q || itim_i_rready || itim_i_flush);
  assign accept        = itim_i_valid && itim_o_ready;

  // Dropped writes and error fetches never touch the RAM.
  assign ram_we   = itim_i_wvalid && !write_bad;
  assign ram_en   = ram_we || (accept && !fetch_bad);
  assign ram_addr = itim_i_wvalid ? write_idx : fetch_idx;

  itim_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_WIDTH(DATA_WIDTH),
    .IMEM_HEX  (IMEM_HEX)
  ) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(itim_i_wdata),
    .wstrb_i(itim_i_wstrb),
    .rdata_o(ram_rdata)
  );

  // Response slot: loaded on accept, emptied on consume or flush, else held.
  always_comb begin
    rvalid_d = rvalid_q;
    rerr_d   = rerr_q;
    if (accept) begin
      rvalid_d = 1'b1;
      rerr_d   = fetch_bad;
    end else if (itim_i_rready || itim_i_flush) begin
      rvalid_d = 1'b0;
      rerr_d   = 1'b0;
    end
  end

  // Response state registers; reset kills any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign itim_o_rvalid = rvalid_q;
  assign itim_o_rerr   = rerr_q;
  // Error and idle responses read as zero; RAM output register is not reset.
  assign itim_o_rdata  = (rvalid_q && !rerr_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_itim_sync.sv
// Bench for itim_sync: table of fetch vectors plus hand sequences, scoreboarded responses.
module tb_itim_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        valid, ready, flush, rvalid, rready, rerr, wvalid, wready;
  logic [31:0] addr, rdata, waddr, wdata;
  logic [3:0]  wstrb;

  // 64-bit instance
  logic        v_valid, v_ready, v_flush, v_rvalid, v_rready, v_rerr, v_wvalid, v_wready;
  logic [31:0] v_addr, v_waddr;
  logic [63:0] v_rdata, v_wdata;
  logic [7:0]  v_wstrb;

  itim_sync #(.ADDR_BITS(10), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .itim_i_valid(valid), .itim_o_ready(ready), .itim_i_addr(addr), .itim_i_flush(flush),
    .itim_o_rvalid(rvalid), .itim_i_rready(rready), .itim_o_rdata(rdata), .itim_o_rerr(rerr),
    .itim_i_wvalid(wvalid), .itim_o_wready(wready), .itim_i_waddr(waddr),
    .itim_i_wdata(wdata), .itim_i_wstrb(wstrb)
  );

  itim_sync #(.ADDR_BITS(10), .DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .itim_i_valid(v_valid), .itim_o_ready(v_ready), .itim_i_addr(v_addr), .itim_i_flush(v_flush),
    .itim_o_rvalid(v_rvalid), .itim_i_rready(v_rready), .itim_o_rdata(v_rdata), .itim_o_rerr(v_rerr),
    .itim_i_wvalid(v_wvalid), .itim_o_wready(v_wready), .itim_i_waddr(v_waddr),
    .itim_i_wdata(v_wdata), .itim_i_wstrb(v_wstrb)
  );

  typedef struct packed { logic err; logic [31:0] data; } resp_t;
  typedef struct { logic [31:0] addr; logic err; logic [31:0] data; } vec_t;

  resp_t q[$];
  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic resp_t mk(input logic e, input logic [31:0] d);
    resp_t r;
    r.err  = e;
    r.data = d;
    return r;
  endfunction

  // Inputs only change just after a rising edge, so values seen at the
  // falling edge are the ones the DUT samples at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (q.size() == 0) chk("rvalid_spurious", 64'(rvalid), 64'd0);
        else begin
          chk("rerr", 64'(rerr), 64'(q[0].err));
          chk("rdata", 64'(rdata), 64'(q[0].data));
          if (rready || flush) void'(q.pop_front());
        end
      end else if (q.size() != 0) begin
        chk("rvalid_missing", 64'(rvalid), 64'd1);
        q.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch and push its expected response once it is accepted.
  // valid is left high so callers can chain requests back to back.
  task automatic issue(input logic [31:0] a, input resp_t e, output int waits);
    logic done;
    done  = 1'b0;
    waits = 0;
    valid = 1'b1;
    addr  = a;
    while (!done && waits < 20) begin
      @(negedge clk);
      #1;
      if (ready) begin
        q.push_back(e);
        done = 1'b1;
      end else waits++;
      step();
    end
    if (!done) chk("accept_timeout", 64'(ready), 64'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wvalid = 1'b1;
    waddr  = a;
    wdata  = d;
    wstrb  = s;
    step();
    wvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl[8];
  int   w;

  initial begin
    valid = 0; addr = 0; flush = 0; rready = 1; wvalid = 0; waddr = 0; wdata = 0; wstrb = 0;
    v_valid = 0; v_addr = 0; v_flush = 0; v_rready = 1; v_wvalid = 0; v_waddr = 0;
    v_wdata = 0; v_wstrb = 0;

    // Word i holds 0x1000_0000 + i after preload.
    tbl[0] = '{32'h0000_0000, 1'b0, 32'h1000_0000};
    tbl[1] = '{32'h0000_0004, 1'b0, 32'h1000_0001};
    tbl[2] = '{32'h0000_0008, 1'b0, 32'h1000_0002};
    tbl[3] = '{32'h0000_0006, 1'b1, 32'h0};
    tbl[4] = '{32'h0000_1000, 1'b1, 32'h0};
    tbl[5] = '{32'h0000_0FFC, 1'b0, 32'h1000_03FF};
    tbl[6] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
    tbl[7] = '{32'h0000_0001, 1'b1, 32'h0};

    #12;
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    chk("reset_rerr",   64'(rerr),   64'd0);
    chk("reset_rdata",  64'(rdata),  64'd0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 1024; i++) wr(32'(i) * 4, 32'h1000_0000 + 32'(i), 4'hF);
    wr(32'h20, 32'h1122_3344, 4'hF);

    // Back-to-back fetches: ready must never stall.
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].addr, mk(tbl[i].err, tbl[i].data), w);
      chk("b2b_stall", 64'(w), 64'd0);
    end
    valid = 0;
    step(); step();

    // Held response for three cycles, next request taken as rready rises.
    rready = 0;
    issue(32'h10, mk(1'b0, 32'h1000_0004), w);
    addr = 32'h14;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("hold_ready", 64'(ready), 64'd0);
      step();
    end
    rready = 1;
    @(negedge clk); #1;
    chk("release_ready", 64'(ready), 64'd1);
    q.push_back(mk(1'b0, 32'h1000_0005));
    step();
    valid = 0;
    step(); step();

    // Write and fetch in the same cycle: fetch stalls, then sees new data.
    valid = 1; addr = 32'h20;
    wvalid = 1; waddr = 32'h20; wdata = 32'hDEAD_BEEF; wstrb = 4'b0011;
    @(negedge clk); #1;
    chk("wr_blocks_ready", 64'(ready), 64'd0);
    chk("wready", 64'(wready), 64'd1);
    step();
    wvalid = 0;
    @(negedge clk); #1;
    chk("post_wr_ready", 64'(ready), 64'd1);
    q.push_back(mk(1'b0, 32'h1122_BEEF));
    step();
    valid = 0;
    step(); step();

    // Write under a held response, null-strobe, out-of-range and misaligned writes.
    rready = 0;
    issue(32'h24, mk(1'b0, 32'h1000_0009), w);
    valid = 0;
    wr(32'h24, 32'hCAFE_F00D, 4'hF);
    wr(32'h28, 32'hFFFF_FFFF, 4'h0);
    wr(32'h1000, 32'hBAD0_BAD0, 4'hF);
    wr(32'h2, 32'hBAD1_BAD1, 4'hF);
    rready = 1;
    step();
    issue(32'h24, mk(1'b0, 32'hCAFE_F00D), w);
    issue(32'h28, mk(1'b0, 32'h1000_000A), w);
    issue(32'h0,  mk(1'b0, 32'h1000_0000), w);
    valid = 0;
    step(); step();

    // Flush a held response while a new request is accepted.
    rready = 0;
    issue(32'h3C, mk(1'b0, 32'h1000_000F), w);
    addr = 32'h40; flush = 1;
    @(negedge clk); #1;
    chk("flush_ready", 64'(ready), 64'd1);
    q.push_back(mk(1'b0, 32'h1000_0010));
    step();
    flush = 0; valid = 0;
    step(); step();
    rready = 1;
    step();

    // Flush alone drops the response; idle flush does nothing.
    rready = 0;
    issue(32'h44, mk(1'b0, 32'h1000_0011), w);
    valid = 0; flush = 1;
    step();
    flush = 0;
    step(); step();
    flush = 1;
    step();
    flush = 0;
    rready = 1;
    step(); step();

    // Reset while a response is held.
    rready = 0;
    issue(32'h20, mk(1'b0, 32'h1122_BEEF), w);
    valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rerr",   64'(rerr),   64'd0);
    chk("rst_rdata",  64'(rdata),  64'd0);
    q.delete();
    step();
    rst_n = 1'b1;
    rready = 1;
    step();
    issue(32'h20, mk(1'b0, 32'h1122_BEEF), w);
    valid = 0;
    step(); step();

    // 64-bit configuration.
    v_wvalid = 1; v_waddr = 32'h8; v_wdata = 64'h0123_4567_89AB_CDEF; v_wstrb = 8'hFF;
    step();
    v_wvalid = 0;
    v_valid = 1; v_addr = 32'h8;
    @(negedge clk); #1;
    chk("w64_ready", 64'(v_ready), 64'd1);
    step();
    v_addr = 32'h4;
    @(negedge clk); #1;
    chk("w64_rvalid", 64'(v_rvalid), 64'd1);
    chk("w64_rerr",   64'(v_rerr),   64'd0);
    chk("w64_rdata",  v_rdata,       64'h0123_4567_89AB_CDEF);
    step();
    v_addr = 32'h2000;
    @(negedge clk); #1;
    chk("w64_mis_rerr",  64'(v_rerr),  64'd1);
    chk("w64_mis_rdata", v_rdata,      64'd0);
    step();
    v_valid = 0;
    @(negedge clk); #1;
    chk("w64_oor_rvalid", 64'(v_rvalid), 64'd1);
    chk("w64_oor_rerr",   64'(v_rerr),   64'd1);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
